// File: rtl/inv_key_schedule.sv
// -----------------------------------------------------------------------------
// inv_key_schedule
//   Sequential AES-128 key schedule for the decryption side. A cipher key is
//   accepted in IDLE, the forward schedule is run one round per cycle up to
//   the round-10 key, then the schedule is walked backwards one round per
//   output handshake, emitting round keys 10 down to 0.
//
//   Optional feature macro: EQUIV_INV_KEY_EN
//     When defined, out_key for rounds 1..9 is InvMixColumns applied to each
//     word (equivalent inverse cipher keys). Rounds 10 and 0 stay raw. The
//     internal key register always holds raw keys.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   cipher key presented
//   in_ready   out  key can be accepted (high only in IDLE)
//   in_key     in   cipher key, word 0 = [127:96], byte 0 of word = [31:24]
//   out_valid  out  out_key/out_round/out_last valid
//   out_ready  in   consumer accepts current round key
//   out_key    out  round key (same layout as in_key)
//   out_round  out  round index of out_key (10..0)
//   out_last   out  high with round 0
// -----------------------------------------------------------------------------
module inv_key_schedule #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_key,
    output logic [3:0]   out_round,
    output logic         out_last
);

    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $error("inv_key_schedule: only NUM_ROUNDS = 10 is supported");
    end

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

`ifdef EQUIV_INV_KEY_EN
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by 9, 11, 13, 14 built from repeated doubling.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return (c[3] ? b8 : 8'h00) ^ (c[2] ? b4 : 8'h00) ^
               (c[1] ? b2 : 8'h00) ^ (c[0] ? b  : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
                gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
                gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
                gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
    endfunction
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_FORWARD,
        S_REVERSE
    } state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic [127:0]   r_key;
    logic           r_out_valid;

    logic [31:0]    w_w0, w_w1, w_w2, w_w3;
    logic [31:0]    w_p3;
    logic [31:0]    w_sub_in;
    logic [31:0]    w_sub_out;
    logic [3:0]     w_rcon_idx;
    logic [31:0]    w_rcon_word;
    logic [31:0]    w_n0, w_n1, w_n2, w_n3;
    logic [31:0]    w_p0;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key;
    assign w_p3 = w_w3 ^ w_w2;

    // Single SubWord shared by both phases: forward uses RotWord(w3), the
    // reverse step needs RotWord of the recovered previous-round w3.
    assign w_sub_in   = (r_state == S_REVERSE) ? {w_p3[23:0], w_p3[31:24]}
                                               : {w_w3[23:0], w_w3[31:24]};
    assign w_sub_out  = {SBOX[w_sub_in[31:24]], SBOX[w_sub_in[23:16]],
                         SBOX[w_sub_in[15:8]],  SBOX[w_sub_in[7:0]]};
    assign w_rcon_idx = (r_state == S_REVERSE) ? r_cnt : r_cnt + 4'd1;
    assign w_rcon_word = {rcon(w_rcon_idx), 24'h000000};

    assign w_n0 = w_w0 ^ w_sub_out ^ w_rcon_word;
    assign w_n1 = w_n0 ^ w_w1;
    assign w_n2 = w_n1 ^ w_w2;
    assign w_n3 = w_n2 ^ w_w3;
    assign w_p0 = w_w0 ^ w_sub_out ^ w_rcon_word;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_key       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_key   <= in_key;
                        r_cnt   <= '0;
                        r_state <= S_FORWARD;
                    end
                end
                S_FORWARD: begin
                    r_key <= {w_n0, w_n1, w_n2, w_n3};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == LAST_RND - 4'd1) begin
                        r_state     <= S_REVERSE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_REVERSE: begin
                    if (r_out_valid && out_ready) begin
                        if (r_cnt != 4'd0) begin
                            r_key <= {w_p0, w_w1 ^ w_w0, w_w2 ^ w_w1, w_p3};
                            r_cnt <= r_cnt - 4'd1;
                        end else begin
                            r_state     <= S_IDLE;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out_round = r_cnt;
    assign out_last  = r_out_valid && (r_cnt == 4'd0);

`ifdef EQUIV_INV_KEY_EN
    always_comb begin
        out_key = r_key;
        if (r_cnt != 4'd0 && r_cnt != LAST_RND) begin
            out_key = {inv_mix_word(w_w0), inv_mix_word(w_w1),
                       inv_mix_word(w_w2), inv_mix_word(w_w3)};
        end
    end
`else
    assign out_key = r_key;
`endif

endmodule

// File: tb/tb_inv_key_schedule.sv
module tb_inv_key_schedule;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic         out_last;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sb [256];
    logic [127:0] rk [11];
    logic [127:0] obs_keys [11];
    logic [127:0] nostall_keys [11];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    inv_key_schedule #(.NUM_ROUNDS(10)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_key   (out_key),
        .out_round (out_round),
        .out_last  (out_last)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // GF(2^8) arithmetic, used to derive the S-box from its definition.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Textbook forward expansion into 44 words, then grouped into round keys.
    task automatic compute_sched(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [31:0] mix_word(input logic [31:0] v);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = v;
        return {gf_mul(a0, 8'd2) ^ gf_mul(a1, 8'd3) ^ a2 ^ a3,
                a0 ^ gf_mul(a1, 8'd2) ^ gf_mul(a2, 8'd3) ^ a3,
                a0 ^ a1 ^ gf_mul(a2, 8'd2) ^ gf_mul(a3, 8'd3),
                gf_mul(a0, 8'd3) ^ a1 ^ a2 ^ gf_mul(a3, 8'd2)};
    endfunction

    // Present a key, check latency, then consume 11 beats with random
    // out_ready at the given percentage. stop_at >= 0 returns (at a negedge)
    // as soon as that round is being presented.
    task automatic run_key(input logic [127:0] key, input int density, input bit hold_busy,
                           input logic [127:0] busy_key, input int stop_at);
        int          cycles;
        int          r;
        int          guard;
        bit          rdy;
        logic [127:0] obs;
        compute_sched(key);
        cycles = 0;
        while (!in_ready && cycles < 50) begin
            @(negedge clock);
            cycles++;
        end
        check("in_ready_idle", 128'(in_ready), 128'(1));
        in_valid  = 1'b1;
        in_key    = key;
        out_ready = 1'b0;
        @(negedge clock);
        if (hold_busy) in_key = busy_key;
        else           in_valid = 1'b0;
        check("in_ready_busy", 128'(in_ready), 128'(0));
        cycles = 0;
        while (!out_valid && cycles < 30) begin
            @(negedge clock);
            cycles++;
        end
        check("first_valid_latency", 128'(cycles), 128'(10));
        r = 10;
        guard = 0;
        while (r >= 0) begin
            if (r == stop_at) return;
            check("out_valid_held", 128'(out_valid), 128'(1));
            check("out_round", 128'(out_round), 128'(r));
            check("out_last", 128'(out_last), 128'(r == 0));
            obs = out_key;
`ifdef EQUIV_INV_KEY_EN
            if (r >= 1 && r <= 9)
                obs = {mix_word(out_key[127:96]), mix_word(out_key[95:64]),
                       mix_word(out_key[63:32]),  mix_word(out_key[31:0])};
`endif
            check("out_key", obs, rk[r]);
            if (hold_busy) check("in_ready_while_busy", 128'(in_ready), 128'(0));
            rdy = ($urandom_range(99) < density);
            out_ready = rdy;
            @(negedge clock);
            if (rdy) begin
                obs_keys[r] = obs;
                r--;
            end
            guard++;
            if (guard > 400) begin
                check("beat_timeout", 128'(0), 128'(1));
                out_ready = 1'b0;
                return;
            end
        end
        out_ready = 1'b0;
        check("out_valid_after_last", 128'(out_valid), 128'(0));
        check("in_ready_after_last", 128'(in_ready), 128'(1));
    endtask

    logic [127:0] other_key;

    initial begin
        build_sbox();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_key    = '0;
        out_ready = 1'b0;
        @(negedge clock);
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_key", out_key, 128'(0));
        check("rst_out_round", 128'(out_round), 128'(0));
        check("rst_out_last", 128'(out_last), 128'(0));
        reset = 1'b0;
        @(negedge clock);

        // FIPS-197 vector, no backpressure
        run_key(FIPS_KEY, 100, 1'b0, '0, -1);
        check("fips_r10", obs_keys[10], FIPS_R10);
        check("fips_r9", obs_keys[9], FIPS_R9);
        check("fips_r0", obs_keys[0], FIPS_KEY);
        for (int i = 0; i < 11; i++) nostall_keys[i] = obs_keys[i];

        // Same key under 30% out_ready density
        run_key(FIPS_KEY, 30, 1'b0, '0, -1);
        for (int i = 0; i < 11; i++) check("stall_seq", obs_keys[i], nostall_keys[i]);

        // Random keys with mixed backpressure
        for (int k = 0; k < 3; k++)
            run_key({$urandom, $urandom, $urandom, $urandom}, 50, 1'b0, '0, -1);

        // Busy input: a different key held on in_valid throughout, then
        // accepted on the first IDLE cycle
        other_key = {$urandom, $urandom, $urandom, $urandom};
        run_key(FIPS_KEY, 100, 1'b1, other_key, -1);
        for (int i = 0; i < 11; i++) check("busy_seq", obs_keys[i], nostall_keys[i]);
        run_key(other_key, 60, 1'b0, '0, -1);

        // Reset while round 5 is presented
        run_key(FIPS_KEY, 100, 1'b0, '0, 5);
        out_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        check("midrst_out_round", 128'(out_round), 128'(0));
        check("midrst_out_key", out_key, 128'(0));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("postrst_out_valid", 128'(out_valid), 128'(0));
        run_key('0, 100, 1'b0, '0, -1);
        check("zero_r10", obs_keys[10], ZERO_R10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
- Sequential AES-128 key schedule for the decryption side. It emits round keys in reverse order, round 10 down to round 0.
- It accepts the cipher key, then runs the forward schedule one round per cycle to reach the round-10 key.
- It then walks the schedule backwards one round per output handshake.
- It feeds the inverse-cipher datapath, which consumes round keys last-to-first.

Parameters:
- NUM_ROUNDS, 10, number of AES-128 rounds. Only 10 is supported; any other value is a compile-time error.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  cipher key presented
- in_ready  output  1  block can accept a key (high only in IDLE)
- in_key  input  128  cipher key; word 0 = [127:96], byte 0 of a word = [31:24]
- out_valid  output  1  out_key/out_round valid
- out_ready  input  1  consumer accepts current round key
- out_key  output  128  round key, same word/byte layout as in_key
- out_round  output  4  round index of out_key (10..0)
- out_last  output  1  high with round 0 (final key of the sequence)

Behaviour:
- Clock/reset: one clock domain. Reset is asynchronous and active-high.
- Reset values:
  - state = IDLE, round counter = 0, key register = 0.
  - out_valid = 0, out_key = 0, out_round = 0, out_last = 0.
  - in_ready = 1, because it is decoded from IDLE and is therefore also 1 while reset is held.
- States:
  - IDLE: in_ready = 1. On in_valid, latch in_key, set counter = 0, go to FORWARD.
  - FORWARD: each cycle, key_reg <= fwd(key_reg, counter+1) and counter <= counter+1.
    - When counter reaches 10, go to REVERSE with out_valid = 1.
  - REVERSE:
    - out_key = key_reg, out_round = counter, out_last = (counter == 0).
    - On out_valid && out_ready with counter > 0: key_reg <= inv(key_reg, counter), counter <= counter-1.
    - On the handshake at counter == 0: go to IDLE with out_valid = 0.
- Latency:
  - Key accepted at edge E0; out_valid first high after edge E10.
  - 11 output beats in total; minimum 21 cycles from accept to IDLE.
- Forward step fwd(k, r), with k = words w0..w3:
  - n0 = w0 ^ SubWord(RotWord(w3)) ^ {RCON[r], 24'h0}
  - n1 = n0 ^ w1, n2 = n1 ^ w2, n3 = n2 ^ w3.
- Inverse step inv(k, r), from round r to round r-1:
  - p3 = w3 ^ w2, p2 = w2 ^ w1, p1 = w1 ^ w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {RCON[r], 24'h0}.
- RotWord rotates left by one byte. SubWord applies the shared forward sbox to each byte.
- RCON[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- One SubWord instance is shared between the forward and reverse phases, which are never active together.
- Handshake rules:
  - While out_valid && !out_ready, out_key, out_round and out_last hold stable.
  - out_valid never drops until its beat is accepted.
  - in_valid outside IDLE is ignored; the key is not captured.
  - in_ready is 0 from the accept edge until the cycle after the round-0 handshake.
- Back-to-back operation:
  - A new key may be accepted in the first IDLE cycle, with no bubble beyond that cycle.
- Reset mid-operation (FORWARD or REVERSE):
  - Return immediately to IDLE with reset values.
  - The partial sequence is discarded; no further beats are emitted.

Optional Feature:
- Macro: EQUIV_INV_KEY_EN
- With the macro defined:
  - For out_round 1..9, out_key = InvMixColumns applied independently to each of the 4 words. This gives the round keys for the equivalent inverse cipher.
  - Rounds 10 and 0 are unchanged.
  - The transform is combinational on the output path only. key_reg and the inverse step always operate on raw keys.
- Without the macro: out_key is always the raw round key, and no InvMixColumns logic is present.

Test Plan:
- FIPS-197 vector, out_ready = 1:
  - Stimulus: in_key = 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: beats with out_round 10, 9, ..., 0 on consecutive cycles.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; round 9 = ac7766f319fadc2128d12941575c006e.
  - Round 0 = 2b7e151628aed2a6abf7158809cf4f3c, with out_last = 1 on round 0 only.
- Latency:
  - Required: first out_valid exactly 10 edges after accept.
  - Required: in_ready returns to 1 the cycle after the round-0 handshake.
- Backpressure:
  - Stimulus: out_ready random at 30% density.
  - Required: out_key/out_round stable across every stall; the beat sequence is identical to the no-stall run.
- Busy input:
  - Stimulus: in_valid held with a different key throughout FORWARD/REVERSE.
  - Required: it is not captured; the output sequence is still the FIPS-197 one; the next key is accepted on the first IDLE cycle.
- Mid-operation reset:
  - Stimulus: assert reset at round 5 of REVERSE.
  - Required: out_valid = 0 and in_ready = 1 immediately; a fresh all-zero key then yields round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- EQUIV_INV_KEY_EN:
  - Stimulus: FIPS-197 key.
  - Required: rounds 10 and 0 match the raw values.
  - Required: for rounds 1..9, applying MixColumns per word to out_key equals the raw round key.
